// File: rtl/storebuf_param.sv
// Parametrised store buffer: age-ordered circular queue (fin/com/ret pointers)
// with speculative kill, append-during-kill and byte-granular load forwarding.
module storebuf_ent_cmp #(
  parameter int ADDR_LEN    = 32,
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   i_valid,
  input  logic                   i_specbit,
  input  logic [ADDR_LEN-1:0]    i_addr,
  input  logic [SPECTAG_LEN-1:0] i_spectag,
  input  logic [ADDR_LEN-1:0]    i_ldaddr,
  input  logic [SPECTAG_LEN-1:0] i_spectagfix,
  input  logic [SPECTAG_LEN-1:0] i_prtag,
  output logic                   o_match,
  output logic                   o_kill,
  output logic                   o_resolve
);
  assign o_match   = i_valid & (i_addr == i_ldaddr);
  assign o_kill    = i_valid & i_specbit & (|(i_spectag & i_spectagfix));
  assign o_resolve = (i_spectag == i_prtag);
endmodule

module storebuf_param #(
  parameter int ENT_NUM     = 4,
  parameter int ENT_SEL     = 2,
  parameter int DATA_LEN    = 32,
  parameter int ADDR_LEN    = 32,
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prsuccess,
  input  logic                   prmiss,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] spectagfix,
  input  logic                   stfin,
  input  logic                   stspecbit,
  input  logic [SPECTAG_LEN-1:0] stspectag,
  input  logic [DATA_LEN-1:0]    stdata,
  input  logic [ADDR_LEN-1:0]    staddr,
  input  logic [DATA_LEN/8-1:0]  stbe,
  input  logic                   stcom,
  input  logic                   memoccupy_ld,
  output logic                   stretire,
  output logic [DATA_LEN-1:0]    retdata,
  output logic [ADDR_LEN-1:0]    retaddr,
  output logic [DATA_LEN/8-1:0]  retbe,
  output logic                   sb_full,
  output logic                   sb_empty,
  output logic [ENT_SEL:0]       sb_count,
  input  logic [ADDR_LEN-1:0]    ldaddr,
  input  logic [DATA_LEN/8-1:0]  ldbe,
  output logic [DATA_LEN-1:0]    lddata,
  output logic                   hit,
  output logic                   hit_partial
);
  localparam int BE_LEN = DATA_LEN/8;
  localparam logic [ENT_SEL:0]   FULL_CNT = (ENT_SEL+1)'(ENT_NUM);
  localparam logic [ENT_SEL-1:0] PTR_ONE  = ENT_SEL'(1);

  logic [ENT_SEL-1:0]                  r_finptr, r_comptr, r_retptr;
  logic [ENT_SEL:0]                    r_count;
  logic [ENT_NUM-1:0]                  r_valid, r_completed, r_specbit;
  logic [ENT_NUM-1:0][DATA_LEN-1:0]    r_data;
  logic [ENT_NUM-1:0][ADDR_LEN-1:0]    r_addr;
  logic [ENT_NUM-1:0][BE_LEN-1:0]      r_be;
  logic [ENT_NUM-1:0][SPECTAG_LEN-1:0] r_spectag;

  logic [ENT_NUM-1:0] w_match, w_kill, w_resolve;
  logic [ENT_NUM-1:0] w_valid_n, w_comp_n, w_spec_n;
  logic [ENT_SEL-1:0] w_kill_ptr, w_alloc_ptr, w_fwd_ptr;
  logic [ENT_SEL:0]   w_nkill, w_post_cnt, w_base_cnt, w_count_n;
  logic               w_full, w_alloc, w_alloc_spec, w_retire;
  logic               w_fwd_match, w_cover;

  for (genvar g = 0; g < ENT_NUM; g++) begin : g_ent
    storebuf_ent_cmp #(.ADDR_LEN(ADDR_LEN), .SPECTAG_LEN(SPECTAG_LEN)) u_cmp (
      .i_valid      (r_valid[g]),
      .i_specbit    (r_specbit[g]),
      .i_addr       (r_addr[g]),
      .i_spectag    (r_spectag[g]),
      .i_ldaddr     (ldaddr),
      .i_spectagfix (spectagfix),
      .i_prtag      (prtag),
      .o_match      (w_match[g]),
      .o_kill       (w_kill[g]),
      .o_resolve    (w_resolve[g])
    );
  end

  // Oldest killed entry: walk youngest-to-oldest from retptr so the oldest wins.
  always_comb begin
    w_kill_ptr = r_finptr;
    w_nkill    = '0;
    for (int k = ENT_NUM-1; k >= 0; k--)
      if (w_kill[r_retptr + ENT_SEL'(k)]) w_kill_ptr = r_retptr + ENT_SEL'(k);
    for (int i = 0; i < ENT_NUM; i++)
      w_nkill = w_nkill + {{ENT_SEL{1'b0}}, w_kill[i]};
  end

  assign w_full       = (r_count == FULL_CNT);
  assign w_post_cnt   = r_count - w_nkill;
  assign w_alloc      = stfin & (prmiss ? (w_post_cnt != FULL_CNT) : ~w_full);
  assign w_alloc_ptr  = prmiss ? w_kill_ptr : r_finptr;
  assign w_alloc_spec = ~prmiss & stspecbit & ~(prsuccess & (stspectag == prtag));
  assign w_retire     = r_valid[r_retptr] & r_completed[r_retptr] & ~memoccupy_ld & ~prmiss;
  assign w_base_cnt   = prmiss ? w_post_cnt : (r_count - {{ENT_SEL{1'b0}}, w_retire});
  assign w_count_n    = w_base_cnt + {{ENT_SEL{1'b0}}, w_alloc};

  always_comb begin
    w_valid_n = r_valid;
    w_comp_n  = r_completed;
    w_spec_n  = r_specbit;
    if (prmiss) begin
      w_valid_n = r_valid & ~w_kill;
      w_comp_n  = r_completed & ~w_kill;
      w_spec_n  = '0;
    end else begin
      if (prsuccess) w_spec_n = r_specbit & ~w_resolve;
      if (w_retire) begin
        w_valid_n[r_retptr] = 1'b0;
        w_comp_n[r_retptr]  = 1'b0;
      end
      if (stcom) w_comp_n[r_comptr] = 1'b1;
    end
    // Append last so a post-kill allocation lands on top of the freed slot.
    if (w_alloc) begin
      w_valid_n[w_alloc_ptr] = 1'b1;
      w_comp_n[w_alloc_ptr]  = 1'b0;
      w_spec_n[w_alloc_ptr]  = w_alloc_spec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_finptr    <= '0;
      r_comptr    <= '0;
      r_retptr    <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_completed <= '0;
      r_specbit   <= '0;
    end else begin
      r_valid     <= w_valid_n;
      r_completed <= w_comp_n;
      r_specbit   <= w_spec_n;
      r_count     <= w_count_n;
      r_finptr    <= w_alloc ? (w_alloc_ptr + PTR_ONE) : w_alloc_ptr;
      if (!prmiss && stcom) r_comptr <= r_comptr + PTR_ONE;
      if (w_retire)         r_retptr <= r_retptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_data[w_alloc_ptr]    <= stdata;
      r_addr[w_alloc_ptr]    <= staddr;
      r_be[w_alloc_ptr]      <= stbe;
      r_spectag[w_alloc_ptr] <= stspectag;
    end
  end

  // Valid entries are contiguous from retptr, so the last match walking
  // oldest-to-youngest is the youngest match behind finptr.
  always_comb begin
    w_fwd_match = 1'b0;
    w_fwd_ptr   = r_retptr;
    for (int k = 0; k < ENT_NUM; k++) begin
      if (w_match[r_retptr + ENT_SEL'(k)]) begin
        w_fwd_match = 1'b1;
        w_fwd_ptr   = r_retptr + ENT_SEL'(k);
      end
    end
  end

  always_comb begin
    lddata = '0;
    for (int b = 0; b < BE_LEN; b++)
      if (w_fwd_match & r_be[w_fwd_ptr][b]) lddata[8*b +: 8] = r_data[w_fwd_ptr][8*b +: 8];
  end

  assign w_cover     = ((r_be[w_fwd_ptr] & ldbe) == ldbe);
  assign hit         = w_fwd_match & w_cover;
  assign hit_partial = w_fwd_match & ~w_cover;

  assign stretire = w_retire;
  assign retdata  = r_data[r_retptr];
  assign retaddr  = r_addr[r_retptr];
  assign retbe    = r_be[r_retptr];
  assign sb_full  = w_full;
  assign sb_empty = (r_count == '0);
  assign sb_count = r_count;
endmodule

// File: tb/tb_storebuf_param.sv
// Scoreboard bench for storebuf_param: stimulus queues expectations, a
// negedge monitor pops and compares status, forwarding and retire traffic.
module tb_storebuf_param;
  localparam int ENT_NUM = 4, ENT_SEL = 2, DATA_LEN = 32, ADDR_LEN = 32, SPECTAG_LEN = 5;
  localparam int S_CNT = 0, S_FULL = 1, S_EMPTY = 2, S_RET = 3, S_HIT = 4,
                 S_PART = 5, S_LDD = 6, S_RADDR = 7;

  logic clk = 1'b0, reset = 1'b1;
  logic prsuccess = 0, prmiss = 0, stfin = 0, stspecbit = 0, stcom = 0, memoccupy_ld = 0;
  logic [SPECTAG_LEN-1:0] prtag = '0, spectagfix = '0, stspectag = '0;
  logic [DATA_LEN-1:0] stdata = '0, retdata, lddata;
  logic [ADDR_LEN-1:0] staddr = '0, retaddr, ldaddr = '0;
  logic [3:0] stbe = '0, retbe, ldbe = '0;
  logic stretire, sb_full, sb_empty, hit, hit_partial;
  logic [ENT_SEL:0] sb_count;

  storebuf_param #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL), .DATA_LEN(DATA_LEN),
                   .ADDR_LEN(ADDR_LEN), .SPECTAG_LEN(SPECTAG_LEN)) dut (
    .clk(clk), .reset(reset), .prsuccess(prsuccess), .prmiss(prmiss), .prtag(prtag),
    .spectagfix(spectagfix), .stfin(stfin), .stspecbit(stspecbit), .stspectag(stspectag),
    .stdata(stdata), .staddr(staddr), .stbe(stbe), .stcom(stcom), .memoccupy_ld(memoccupy_ld),
    .stretire(stretire), .retdata(retdata), .retaddr(retaddr), .retbe(retbe),
    .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count),
    .ldaddr(ldaddr), .ldbe(ldbe), .lddata(lddata), .hit(hit), .hit_partial(hit_partial));

  always #5 clk = ~clk;

  typedef struct { string name; int sel; logic [31:0] val; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } ret_t;
  exp_t exp_q[$];
  ret_t ret_q[$];
  int n_chk = 0, n_pass = 0;

  function automatic logic [31:0] pick(int sel);
    case (sel)
      S_CNT:   return {29'd0, sb_count};
      S_FULL:  return {31'd0, sb_full};
      S_EMPTY: return {31'd0, sb_empty};
      S_RET:   return {31'd0, stretire};
      S_HIT:   return {31'd0, hit};
      S_PART:  return {31'd0, hit_partial};
      S_LDD:   return lddata;
      default: return retaddr;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    ret_t r;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (pick(e.sel) === e.val) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, pick(e.sel), e.val);
    end
    if (stretire === 1'b1) begin
      n_chk++;
      if (ret_q.size() == 0)
        $display("FAIL retire_unexpected: got addr 0x%0h expected no retire", retaddr);
      else begin
        r = ret_q.pop_front();
        if (retaddr === r.addr && retdata === r.data && retbe === r.be) n_pass++;
        else $display("FAIL retire_txn: got %h/%h/%h expected %h/%h/%h",
                      retaddr, retdata, retbe, r.addr, r.data, r.be);
      end
    end
  end

  task automatic ex(string name, int sel, logic [31:0] val);
    exp_t e;
    e.name = name; e.sel = sel; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic exr(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    ret_t r;
    r.addr = a; r.data = d; r.be = be;
    ret_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    stfin = 0; stcom = 0; prmiss = 0; prsuccess = 0; memoccupy_ld = 0; stspecbit = 0;
    prtag = '0; spectagfix = '0; stspectag = '0; ldaddr = '0; ldbe = '0;
  endtask

  task automatic set_st(logic [31:0] a, logic [31:0] d, logic [3:0] be, logic sp, logic [4:0] tag);
    stfin = 1; staddr = a; stdata = d; stbe = be; stspecbit = sp; stspectag = tag;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  initial begin
    // Reset state and fill to full
    do_reset();
    ex("rst_count", S_CNT, 0); ex("rst_empty", S_EMPTY, 1); ex("rst_full", S_FULL, 0);
    ex("rst_stretire", S_RET, 0); ex("rst_hit", S_HIT, 0); ex("rst_partial", S_PART, 0);
    tick();
    for (int i = 0; i < 4; i++) begin set_st(32'h10 + i, 32'h100 + i, 4'hF, 0, 0); tick(); end
    set_st(32'h14, 32'hDEAD, 4'hF, 0, 0); ldaddr = 32'h12; ldbe = 4'hF;
    ex("full4", S_FULL, 1); ex("count4", S_CNT, 4); ex("ld_full_hit", S_HIT, 1);
    ex("ld_full_data", S_LDD, 32'h102);
    tick();
    for (int i = 0; i < 4; i++) exr(32'h10 + i, 32'h100 + i, 4'hF);
    stcom = 1; ex("fifth_ignored_count", S_CNT, 4); ex("no_ret_uncommitted", S_RET, 0); tick();
    stcom = 1; set_st(32'h15, 32'hBEEF, 4'hF, 0, 0);
    ex("full_ret_flag", S_RET, 1); ex("full_at_retfin", S_FULL, 1); tick();
    stcom = 1; ex("full_retfin_count", S_CNT, 3); tick();
    stcom = 1; tick();
    tick();
    ex("t1_empty", S_EMPTY, 1); ex("t1_count0", S_CNT, 0); ex("t1_noret", S_RET, 0); tick();

    // Retire blocked by a load using the memory port
    do_reset();
    set_st(32'h10, 32'hA0, 4'hF, 0, 0); tick();
    set_st(32'h11, 32'hA1, 4'hF, 0, 0); tick();
    exr(32'h10, 32'hA0, 4'hF); exr(32'h11, 32'hA1, 4'hF);
    stcom = 1; tick();
    stcom = 1; memoccupy_ld = 1; ex("occupy_blocks", S_RET, 0); tick();
    ex("ret_first", S_RET, 1); ex("ret_addr0", S_RADDR, 32'h10); tick();
    ex("ret_second", S_RET, 1); ex("ret_addr1", S_RADDR, 32'h11); tick();
    ex("t2_empty", S_EMPTY, 1); ex("t2_noret", S_RET, 0); tick();

    // Forwarding: youngest match, byte enables, partial coverage
    do_reset();
    set_st(32'h20, 32'h11223344, 4'hF, 0, 0); ldaddr = 32'h20; ldbe = 4'h3;
    ex("ld_empty_hit", S_HIT, 0); ex("ld_empty_data", S_LDD, 0); tick();
    set_st(32'h20, 32'hAABBCCDD, 4'h3, 0, 0); ldaddr = 32'h20; ldbe = 4'h3;
    ex("ld_samecyc_hit", S_HIT, 1); ex("ld_samecyc_data", S_LDD, 32'h11223344); tick();
    ldaddr = 32'h20; ldbe = 4'h3;
    ex("fwd_hit", S_HIT, 1); ex("fwd_data", S_LDD, 32'h0000CCDD); ex("fwd_nopart", S_PART, 0); tick();
    ldaddr = 32'h20; ldbe = 4'hF;
    ex("fwd_partial", S_PART, 1); ex("fwd_partial_nohit", S_HIT, 0); tick();
    ldaddr = 32'h24; ldbe = 4'hF;
    ex("nomatch_hit", S_HIT, 0); ex("nomatch_part", S_PART, 0); ex("nomatch_data", S_LDD, 0); tick();

    // Mispredict kills the speculative suffix; next store lands at entry 1
    do_reset();
    set_st(32'h30, 32'h30, 4'hF, 0, 0); tick();
    set_st(32'h31, 32'h31, 4'hF, 1, 5'b00010); tick();
    set_st(32'h32, 32'h32, 4'hF, 1, 5'b00010); tick();
    prmiss = 1; spectagfix = 5'b00010; prtag = 5'b00010; ex("pre_kill_cnt", S_CNT, 3); tick();
    ex("post_kill_cnt", S_CNT, 1); set_st(32'h34, 32'h34, 4'hF, 0, 0); tick();
    exr(32'h30, 32'h30, 4'hF); exr(32'h34, 32'h34, 4'hF);
    stcom = 1; ldaddr = 32'h31; ldbe = 4'hF;
    ex("after_kill_app_cnt", S_CNT, 2); ex("killed_nohit", S_HIT, 0); ex("killed_nopart", S_PART, 0); tick();
    stcom = 1; tick();
    tick();
    ex("t4_empty", S_EMPTY, 1); tick();

    // Append during kill: new entry takes the oldest killed slot, non-speculative
    do_reset();
    set_st(32'h40, 32'h40, 4'hF, 0, 0); tick();
    set_st(32'h41, 32'h41, 4'hF, 1, 5'b01000); tick();
    set_st(32'h42, 32'h42, 4'hF, 1, 5'b01000); tick();
    prmiss = 1; spectagfix = 5'b01000; prtag = 5'b01000; set_st(32'h43, 32'h43, 4'hF, 1, 5'b00001);
    ex("killapp_pre_cnt", S_CNT, 3); tick();
    prmiss = 1; spectagfix = 5'b00001; prtag = 5'b00001; ex("killapp_cnt", S_CNT, 2); tick();
    exr(32'h40, 32'h40, 4'hF); exr(32'h43, 32'h43, 4'hF);
    stcom = 1; ldaddr = 32'h43; ldbe = 4'hF;
    ex("app_nonspec_cnt", S_CNT, 2); ex("app_fwd_hit", S_HIT, 1); ex("app_fwd_data", S_LDD, 32'h43); tick();
    stcom = 1; ldaddr = 32'h42; ldbe = 4'hF; ex("killed42_nohit", S_HIT, 0); ex("killed42_nopart", S_PART, 0); tick();
    tick();
    ex("t5_empty", S_EMPTY, 1); tick();

    // prsuccess clears specbit, including a store allocated the same cycle
    do_reset();
    set_st(32'h50, 32'h50, 4'hF, 1, 5'b00100); tick();
    set_st(32'h51, 32'h51, 4'hF, 1, 5'b00100); prsuccess = 1; prtag = 5'b00100; tick();
    prmiss = 1; spectagfix = 5'b00100; prtag = 5'b00100; ex("res_pre_cnt", S_CNT, 2); tick();
    exr(32'h50, 32'h50, 4'hF); exr(32'h51, 32'h51, 4'hF);
    stcom = 1; ldaddr = 32'h51; ldbe = 4'hF;
    ex("res_survive_cnt", S_CNT, 2); ex("res_fwd_hit", S_HIT, 1); ex("res_fwd_data", S_LDD, 32'h51); tick();
    stcom = 1; tick();
    tick();
    ex("t6_empty", S_EMPTY, 1); tick();

    // Reset wins over a simultaneous kill and allocate
    set_st(32'h60, 32'h60, 4'hF, 1, 5'b00001); tick();
    reset = 1; prmiss = 1; spectagfix = 5'b00001; set_st(32'h61, 32'h61, 4'hF, 0, 0); tick();
    reset = 0; ex("rst_pri_cnt", S_CNT, 0); ex("rst_pri_empty", S_EMPTY, 1); tick();
    tick();

    n_chk++;
    if (ret_q.size() == 0) n_pass++;
    else $display("FAIL retire_drain: got %0d pending expected 0", ret_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/storebuf_param.md
Name: storebuf_param

Overview:
- Parametrised store buffer between the LSU store pipe and data memory, successor to the fixed 5-bit-tag store buffer.
- Holds finished stores in an age-ordered circular queue with three pointers:
  - fin: allocate
  - com: commit
  - ret: retire to memory
- Adds per-entry speculative tag storage, byte enables, partial-overlap load detection, occupancy count, and append-during-kill.
- Loads search it combinationally for store-to-load forwarding.

Parameters:
- ENT_NUM, 4, number of entries (power of two, >=2)
- ENT_SEL, 2, log2(ENT_NUM)
- DATA_LEN, 32, data width in bits (multiple of 8)
- ADDR_LEN, 32, word address width
- SPECTAG_LEN, 5, one-hot speculative tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- prsuccess  in  1  branch resolved correct
- prmiss  in  1  branch mispredicted
- prtag  in  SPECTAG_LEN  tag of resolving branch
- spectagfix  in  SPECTAG_LEN  mask of tags killed on prmiss
- stfin  in  1  store finished, allocate entry
- stspecbit  in  1  store is speculative
- stspectag  in  SPECTAG_LEN  store's tag
- stdata  in  DATA_LEN  store data
- staddr  in  ADDR_LEN  store word address
- stbe  in  DATA_LEN/8  store byte enables
- stcom  in  1  oldest uncommitted store committed by ROB
- memoccupy_ld  in  1  memory port used by a load this cycle
- stretire  out  1  write-enable to dmem
- retdata  out  DATA_LEN  data at retptr
- retaddr  out  ADDR_LEN  address at retptr
- retbe  out  DATA_LEN/8  byte enables at retptr
- sb_full  out  1  all entries valid
- sb_empty  out  1  no entries valid
- sb_count  out  ENT_SEL+1  valid entry count
- ldaddr  in  ADDR_LEN  load word address
- ldbe  in  DATA_LEN/8  load byte enables
- lddata  out  DATA_LEN  forwarded data
- hit  out  1  youngest matching entry covers all ldbe bytes
- hit_partial  out  1  match exists but coverage incomplete; load must stall

Behaviour:
- Reset:
  - finptr/comptr/retptr = 0; valid, completed, specbit all 0; count = 0.
  - Resulting outputs: sb_empty=1, sb_full=0, stretire=0, hit=0, hit_partial=0.
  - Entry data/addr/be/spectag are not reset.
  - Reset has priority over all other inputs in any cycle, including mid-kill.
- Allocate (stfin, not full):
  - Write data/addr/be/spectag/specbit at finptr.
  - Set valid=1, completed=0; finptr+1 mod ENT_NUM.
  - stfin while sb_full is ignored: no state change.
- Commit (stcom, no prmiss): set completed[comptr]; comptr+1.
- stretire = valid[retptr] & completed[retptr] & ~memoccupy_ld & ~prmiss.
  - When asserted: clear valid/completed at retptr; retptr+1.
- Without prmiss, stfin, stcom and stretire may all occur in one cycle.
  - Count changes by +1 for stfin and -1 for stretire.
  - stfin and stretire in the same cycle when full: the retire frees a slot the same cycle, but stfin is still ignored because full is sampled before the update.
- prsuccess (no prmiss): specbit[i] cleared where spectag[i]==prtag.
  - A stfin entry in the same cycle is compared too; its specbit = stspecbit & (stspectag!=prtag).
- prmiss kill:
  - Entry i is killed if valid & specbit & ((spectag[i] & spectagfix)!=0).
  - Killed entries form the youngest suffix of the queue.
  - finptr moves to the oldest killed entry, found by age-ordered search from retptr; unchanged if none killed.
  - Killed valid bits are cleared; all specbit cleared; comptr and retptr unchanged.
  - stcom and stretire are ignored this cycle.
- prmiss with stfin: the kill is applied first, then the new entry is appended at the post-kill finptr with specbit=0.
  - If the buffer is full and nothing is killed, stfin is ignored.
- Pointer and count arithmetic is mod ENT_NUM; sb_count ranges 0..ENT_NUM.
  - sb_full = (count==ENT_NUM); sb_empty = (count==0).
- Forwarding (combinational, same cycle):
  - Match = valid & addr==ldaddr.
  - Select the youngest match, searching backward from finptr-1 to retptr.
  - lddata byte k = entry byte k if entry be[k], else 0.
  - hit = match & ((be & ldbe)==ldbe).
  - hit_partial = match & ~hit.
  - No match gives hit=0, hit_partial=0, lddata=0.
  - Stores allocated in the current cycle are not visible until the next cycle.

Test Plan:
- Reset, 4 stfin (addr 0x10..0x13, be 0xF), no stcom -> sb_full=1, sb_count=4; 5th stfin ignored, finptr stays 0.
- 2 stores, stcom x2, memoccupy_ld=1 one cycle then 0 -> stretire low for the first cycle, then high 2 consecutive cycles; retaddr 0x10 then 0x11; sb_empty=1 after.
- Stores A (addr 0x20, data 0x11223344, be 0xF) then B (addr 0x20, data 0xAABBCCDD, be 0x3):
  - ld 0x20, be 0x3 -> hit=1, lddata=0x0000CCDD.
  - ld be 0xF -> hit_partial=1.
- Nonspec store, then 2 stores with tag 0b00010; prmiss with spectagfix=0b00010 -> finptr=1, sb_count=1; the next stfin lands at entry 1.
- prmiss killing 2 of 3 entries with simultaneous stfin -> new entry at the oldest killed slot, sb_count=2, specbit=0.
- Spec store with tag 0b00100, then prsuccess with prtag=0b00100 -> a later prmiss with spectagfix=0b00100 kills nothing.
